// File: rtl/control_unit.sv
// Timestep sequencer for the 4-bit shared-bus datapath.
// Accepts one instruction per handshake and walks T0..T3 driving bus strobes.
module control_unit #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [3:0]        instr,
  input  logic [DATA_W-1:0] imm,
  output logic              instr_ready,
  output logic [DATA_W-1:0] ext_data,
  output logic              ExtOut,
  output logic              R0in,
  output logic              R0out,
  output logic              R1in,
  output logic              R1out,
  output logic              Ain,
  output logic              Gin,
  output logic              Gout,
  output logic              AddSub,
  output logic              done
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [1:0] OP_MV = 2'b00;
  localparam logic [1:0] OP_LD = 2'b01;

  state_t            state;
  logic [1:0]        op;
  logic              rx;
  logic              ry;
  logic [DATA_W-1:0] imm_q;

  logic rx_in;
  logic rx_out;
  logic ry_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= T0;
      op    <= 2'b00;
      rx    <= 1'b0;
      ry    <= 1'b0;
      imm_q <= '0;
    end else begin
      unique case (state)
        T0: begin
          if (instr_valid) begin
            op    <= instr[3:2];
            rx    <= instr[1];
            ry    <= instr[0];
            imm_q <= imm;
            state <= T1;
          end
        end
        T1: state <= op[1] ? T2 : T0;
        T2: state <= T3;
        T3: state <= T0;
        default: state <= T0;
      endcase
    end
  end

  assign instr_ready = rst & (state == T0);
  assign ext_data    = imm_q;

  // Strobes depend only on registered state and latched fields.
  always_comb begin
    rx_in  = 1'b0;
    rx_out = 1'b0;
    ry_out = 1'b0;
    ExtOut = 1'b0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    Gout   = 1'b0;
    AddSub = 1'b0;
    done   = 1'b0;
    unique case (1'b1)
      (state == T1) && (op == OP_MV): begin
        ry_out = 1'b1;
        rx_in  = 1'b1;
        done   = 1'b1;
      end
      (state == T1) && (op == OP_LD): begin
        ExtOut = 1'b1;
        rx_in  = 1'b1;
        done   = 1'b1;
      end
      (state == T1) && op[1]: begin
        rx_out = 1'b1;
        Ain    = 1'b1;
      end
      (state == T2): begin
        ry_out = 1'b1;
        Gin    = 1'b1;
        AddSub = op[0];
      end
      (state == T3): begin
        Gout  = 1'b1;
        rx_in = 1'b1;
        done  = 1'b1;
      end
      default: ;
    endcase
  end

  assign R0in  = rx_in & ~rx;
  assign R1in  = rx_in & rx;
  assign R0out = (rx_out & ~rx) | (ry_out & ~ry);
  assign R1out = (rx_out & rx) | (ry_out & ry);

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit with a behavioural bus datapath.
// Directed strobe checks plus random instruction streams vs. a register model.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [3:0] instr;
  logic [3:0] imm;
  logic       instr_ready;
  logic [3:0] ext_data;
  logic       ExtOut, R0in, R0out, R1in, R1out;
  logic       Ain, Gin, Gout, AddSub, done;

  int passed = 0;
  int total  = 0;

  localparam logic [9:0] B_EXT  = 10'b1000000000;
  localparam logic [9:0] B_R0I  = 10'b0100000000;
  localparam logic [9:0] B_R0O  = 10'b0010000000;
  localparam logic [9:0] B_R1I  = 10'b0001000000;
  localparam logic [9:0] B_R1O  = 10'b0000100000;
  localparam logic [9:0] B_AIN  = 10'b0000010000;
  localparam logic [9:0] B_GIN  = 10'b0000001000;
  localparam logic [9:0] B_GOUT = 10'b0000000100;
  localparam logic [9:0] B_SUB  = 10'b0000000010;
  localparam logic [9:0] B_DONE = 10'b0000000001;

  control_unit #(.DATA_W(4)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid),
    .instr(instr), .imm(imm), .instr_ready(instr_ready),
    .ext_data(ext_data), .ExtOut(ExtOut),
    .R0in(R0in), .R0out(R0out), .R1in(R1in), .R1out(R1out),
    .Ain(Ain), .Gin(Gin), .Gout(Gout),
    .AddSub(AddSub), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural shared-bus datapath driven by the DUT strobes.
  logic [3:0] r0 = 4'h0;
  logic [3:0] r1 = 4'h0;
  logic [3:0] ra = 4'h0;
  logic [3:0] rg = 4'h0;

  always @(posedge clk) begin
    logic [3:0] bus;
    bus = ExtOut ? ext_data :
          R0out  ? r0 :
          R1out  ? r1 :
          Gout   ? rg : 4'h0;
    if (R0in) r0 <= bus;
    if (R1in) r1 <= bus;
    if (Ain)  ra <= bus;
    if (Gin)  rg <= AddSub ? ra - bus : ra + bus;
  end

  always @(negedge clk) begin
    total++;
    if ($countones({R0out, R1out, Gout, ExtOut}) > 1)
      $display("FAIL bus_driver t=%0t got %b required <=1 driver",
               $time, {R0out, R1out, Gout, ExtOut});
    else
      passed++;
  end

  function automatic logic [9:0] sv();
    return {ExtOut, R0in, R0out, R1in, R1out,
            Ain, Gin, Gout, AddSub, done};
  endfunction

  logic [9:0] snap [4];
  int         lat;
  logic [3:0] ext_at_done;
  logic       ready_after;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [9:0] got,
                     input logic [9:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s got %h required %h", nm, got, exp);
    else
      passed++;
  endtask

  task automatic issue(input logic [3:0] ins, input logic [3:0] im);
    int n;
    instr_valid = 1'b1;
    instr = ins;
    imm = im;
    n = 0;
    while (!instr_ready && n < 20) begin
      step();
      n++;
    end
    total++;
    if (!instr_ready)
      $display("FAIL issue_ready got 0 required 1");
    else
      passed++;
    step();
    instr_valid = 1'b0;
    instr = 4'($urandom);
    imm = 4'($urandom);
    for (int i = 0; i < 4; i++) snap[i] = '0;
    lat = 1;
    snap[0] = sv();
    while (!done && lat < 6) begin
      step();
      if (lat < 4) snap[lat] = sv();
      lat++;
    end
    ext_at_done = ext_data;
    step();
    ready_after = instr_ready;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    instr_valid = 1'b0;
    instr = 4'h0;
    imm = 4'h0;
    #3;
    chk("rst_strobes", sv(), 10'h0);
    chk("rst_ready", {9'h0, instr_ready}, 10'h0);
    chk("rst_ext", {6'h0, ext_data}, 10'h0);
    step();
    step();
    rst = 1'b1;
    step();
    chk("rst_release_ready", {9'h0, instr_ready}, 10'h1);
  endtask

  task automatic test_reset_mid_add();
    instr_valid = 1'b1;
    instr = 4'b1001;
    imm = 4'h7;
    step();
    instr_valid = 1'b0;
    chk("mid_t1_ext", {6'h0, ext_data}, 10'h7);
    step();
    chk("mid_t2", sv(), B_R1O | B_GIN);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_strobes", sv(), 10'h0);
    chk("mid_rst_ext", {6'h0, ext_data}, 10'h0);
    chk("mid_rst_ready", {9'h0, instr_ready}, 10'h0);
    step();
    rst = 1'b1;
    step();
    chk("mid_after_ready", {9'h0, instr_ready}, 10'h1);
    chk("mid_after_strobes", sv(), 10'h0);
  endtask

  task automatic test_ld();
    issue(4'b0110, 4'hA);
    chk("ld_t1", snap[0], B_EXT | B_R1I | B_DONE);
    chk("ld_lat", 10'(lat), 10'd1);
    chk("ld_ext", {6'h0, ext_at_done}, 10'hA);
    chk("ld_ready", {9'h0, ready_after}, 10'h1);
    chk("ld_r1", {6'h0, r1}, 10'hA);
  endtask

  task automatic test_back_to_back();
    int d0;
    int d1;
    issue(4'b0100, 4'h5);
    instr_valid = 1'b1;
    instr = 4'b0010;
    step();
    chk("b2b_t1a", sv(), B_R0O | B_R1I | B_DONE);
    d0 = int'($time);
    instr = 4'b0001;
    step();
    chk("b2b_t0", sv(), 10'h0);
    step();
    chk("b2b_t1b", sv(), B_R1O | B_R0I | B_DONE);
    d1 = int'($time);
    instr_valid = 1'b0;
    chk("b2b_gap", 10'((d1 - d0) / 10), 10'd2);
    step();
    chk("b2b_r1", {6'h0, r1}, 10'h5);
    chk("b2b_r0", {6'h0, r0}, 10'h5);
  endtask

  task automatic test_add();
    issue(4'b0100, 4'h3);
    issue(4'b0110, 4'h5);
    issue(4'b1001, 4'hF);
    chk("add_t1", snap[0], B_R0O | B_AIN);
    chk("add_t2", snap[1], B_R1O | B_GIN);
    chk("add_t3", snap[2], B_GOUT | B_R0I | B_DONE);
    chk("add_lat", 10'(lat), 10'd3);
    chk("add_r0", {6'h0, r0}, 10'h8);
  endtask

  task automatic test_sub();
    issue(4'b0110, 4'h6);
    issue(4'b1111, 4'h0);
    chk("sub_t1", snap[0], B_R1O | B_AIN);
    chk("sub_t2", snap[1], B_R1O | B_GIN | B_SUB);
    chk("sub_t3", snap[2], B_GOUT | B_R1I | B_DONE);
    chk("sub_r1", {6'h0, r1}, 10'h0);
  endtask

  task automatic test_stall();
    issue(4'b0100, 4'h2);
    issue(4'b0110, 4'h3);
    instr_valid = 1'b1;
    instr = 4'b1001;
    imm = 4'h0;
    step();
    instr = 4'b0100;
    imm = 4'h1;
    step();
    chk("stall_busy_ready", {9'h0, instr_ready}, 10'h0);
    instr = 4'b0110;
    imm = 4'hC;
    step();
    step();
    chk("stall_t0_ready", {9'h0, instr_ready}, 10'h1);
    step();
    instr_valid = 1'b0;
    chk("stall_t1", sv(), B_EXT | B_R1I | B_DONE);
    chk("stall_ext", {6'h0, ext_data}, 10'hC);
    step();
    chk("stall_r0", {6'h0, r0}, 10'h5);
    chk("stall_r1", {6'h0, r1}, 10'hC);
  endtask

  task automatic test_random();
    logic [3:0] m [2];
    logic [3:0] ins;
    logic [3:0] im;
    logic [1:0] op;
    int         x;
    int         y;
    m[0] = 4'h9;
    m[1] = 4'h4;
    issue(4'b0100, m[0]);
    issue(4'b0110, m[1]);
    for (int k = 0; k < 40; k++) begin
      ins = 4'($urandom);
      im = 4'($urandom);
      op = ins[3:2];
      x = int'(ins[1]);
      y = int'(ins[0]);
      repeat ($urandom_range(0, 2)) step();
      issue(ins, im);
      case (op)
        2'b00: m[x] = m[y];
        2'b01: m[x] = im;
        2'b10: m[x] = 4'((int'(m[x]) + int'(m[y])) % 16);
        default: m[x] = 4'((int'(m[x]) - int'(m[y]) + 16) % 16);
      endcase
      total++;
      if (lat != (op[1] ? 3 : 1))
        $display("FAIL rnd_lat k=%0d got %0d required %0d",
                 k, lat, op[1] ? 3 : 1);
      else
        passed++;
      total++;
      if (r0 !== m[0] || r1 !== m[1])
        $display("FAIL rnd_regs k=%0d ins=%b got %h,%h required %h,%h",
                 k, ins, r0, r1, m[0], m[1]);
      else
        passed++;
      total++;
      if (ready_after !== 1'b1)
        $display("FAIL rnd_ready k=%0d got %b required 1", k, ready_after);
      else
        passed++;
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_add();
    test_ld();
    test_back_to_back();
    test_add();
    test_sub();
    test_stall();
    test_random();
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running required finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction sequencer that drives the register-transfer strobes of the 4-bit shared-bus datapath (R0, R1, accumulator A, result G). It accepts one 4-bit instruction at a time through a valid/ready handshake and steps a timestep state machine (T0–T3), asserting the in/out enables so that exactly one source drives the bus per cycle. It sits directly upstream of the datapath top level and replaces hand-driven strobes in the benches.

## Interface
- DATA_W, 4, width of the immediate operand and the bus.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- instr_valid  in  1  instruction offered this cycle.
- instr  in  4  [3:2] opcode (00 MV, 01 LD, 10 ADD, 11 SUB), [1] rx, [0] ry (0=R0, 1=R1).
- imm  in  DATA_W  immediate for LD, sampled with instr.
- instr_ready  out  1  sequencer can accept an instruction.
- ext_data  out  DATA_W  latched immediate, put on the bus by the datapath when ExtOut=1.
- ExtOut, R0in, R0out, R1in, R1out, Ain, Gin, Gout  out  1 each  datapath bus/load strobes.
- AddSub  out  1  ALU op: 0 add, 1 subtract; meaningful only while Gin=1.
- done  out  1  one-cycle pulse in the final timestep of an instruction.

## Operation
- States: T0 (idle), T1, T2, T3. Held in a 2-bit register with latched opcode, rx, ry and imm.
- T0: instr_ready = 1 (gated low while rst = 0). On instr_valid & instr_ready at a clock edge: latch instr and imm, go to T1. With no valid instruction, stay in T0. All strobes are 0.
- MV Rx,Ry: T1: Ry_out, Rx_in, done. Then T0.
- LD Rx: T1: ExtOut, Rx_in, done. Then T0. ext_data = latched imm.
- ADD/SUB Rx,Ry: T1: Rx_out, Ain. T2: Ry_out, Gin, AddSub = opcode[0]. T3: Gout, Rx_in, done. Then T0.
- Strobes are a combinational decode of the registered state and latched fields only, never of live inputs.
- Invariant: at most one of {R0out, R1out, Gout, ExtOut} is high in any cycle.
- rx == ry is legal:
  - MV asserts Rx_out and Rx_in together (self-reload, no change).
  - ADD R0,R0 doubles R0.
  - SUB R0,R0 yields 0.
- Arithmetic is performed in the datapath, modulo 2^DATA_W. This block only selects the operation.
- instr and imm are ignored outside T0. They may change freely while busy.

## Timing
- Reset (rst low): asynchronously forces state T0 and clears latched fields and ext_data to 0. All strobes, done and AddSub are 0. instr_ready is 0 while rst is low and becomes 1 in the first cycle after rst is released.
- Reset mid-instruction: the instruction is abandoned with no further strobes. Register contents are not restored.
- Latency from the accept edge to done:
  - MV and LD: 1 cycle (busy 1 cycle).
  - ADD and SUB: 3 cycles.
- Back-to-back: done is asserted in the last timestep, and the sequencer is in T0 (ready) on the following cycle. Peak throughput is one MV/LD every 2 cycles and one ADD/SUB every 4 cycles.
- instr_ready is low in T1–T3. An instr_valid held during that time is accepted on the first T0 edge.

## Test plan
- Reset: drive rst = 0 mid-ADD (in T2). All strobes go 0 immediately without waiting for clk, ext_data = 0, instr_ready = 0. After release, instr_ready = 1 on the next cycle.
- LD R1, imm = 4'hA: one cycle after accept, ExtOut = R1in = done = 1 and ext_data = 4'hA. Back in T0 the following cycle with instr_ready = 1.
- MV R1,R0 then MV R0,R1, back-to-back with instr_valid held high:
  - first T1: R0out = R1in = 1;
  - next T0: no strobes;
  - next T1: R1out = R0in = 1;
  - done pulses twice, 2 cycles apart.
- ADD R0,R1 (instr = 4'b1001):
  - T1: R0out = Ain = 1;
  - T2: R1out = Gin = 1 with AddSub = 0;
  - T3: Gout = R0in = done = 1.
  - With the datapath loaded R0 = 3, R1 = 5, R0 ends at 8.
- SUB R1,R1 (4'b1111): AddSub = 1 during T2, and R1 ends at 0. Check that the single-bus-driver invariant holds every cycle.
- Handshake stall: present a new instr while busy, then change instr and imm before T0. Only the value present at the T0 accept edge is executed.
